// File: rtl/stream_demux_pkg.sv
// ==== stream_demux_pkg : shared defaults and lane index type for the demux ====
// ==== rev 1.0 ====
`default_nettype none

package stream_demux_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_SEL_W   = $clog2(DEF_NUM_OUT);

  typedef logic [DEF_SEL_W-1:0] lane_idx_t;

endpackage

`default_nettype wire

// File: rtl/demux_lane_buf.sv
// ==== demux_lane_buf : single-entry output register with delivered-word counter ====
// ==== rev 1.0 ====
`default_nettype none

module demux_lane_buf
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_cnt
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_deliver;

  assign w_deliver = r_valid & i_ready;

  // Load wins over drain so a word can leave and a new one land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (w_deliver || i_flush) begin
        r_valid <= 1'b0;
      end
      if (w_deliver) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ==== stream_demux : 1-to-NUM_OUT valid/ready demultiplexer with per-lane buffers ====
// ==== rev 1.0 ====
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NUM_OUT = DEF_NUM_OUT,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*CNT_W-1:0] out_cnt
);

  logic [NUM_OUT-1:0] w_load;
  logic [NUM_OUT-1:0] w_valid;

  // Only the selected lane's occupancy gates the input; other lanes may be stalled freely.
  assign in_ready = !rst && !flush && (!w_valid[in_sel] || out_ready[in_sel]);

  always_comb begin
    w_load = '0;
    if (in_valid && in_ready) begin
      w_load[in_sel] = 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
      demux_lane_buf #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[g]),
        .i_flush (flush),
        .i_data  (in_data),
        .i_ready (out_ready[g]),
        .o_data  (out_data[g*WIDTH +: WIDTH]),
        .o_valid (w_valid[g]),
        .o_cnt   (out_cnt[g*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign out_valid = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ==== tb_stream_demux : directed stimulus with per-lane scoreboard for stream_demux ====
// ==== rev 1.0 ====
`default_nettype none

module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic [W-1:0]   in_data = '0;
  lane_idx_t      in_sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic [N*CW-1:0] out_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  sb [N][$];
  logic [N-1:0]  m_valid;
  logic [CW-1:0] m_cnt [N];
  logic          exp_rdy;
  logic [W-1:0]  exp_word;

  stream_demux #(
    .WIDTH   (W),
    .NUM_OUT (N),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model evaluated mid-cycle, when inputs and DUT outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {60'd0, out_valid}, 64'd0);
      m_valid = '0;
      for (int l = 0; l < N; l++) begin
        m_cnt[l] = '0;
        sb[l].delete();
      end
    end else begin
      check("out_valid", {60'd0, out_valid}, {60'd0, m_valid});
      for (int l = 0; l < N; l++) begin
        check("out_cnt", {60'd0, out_cnt[l*CW +: CW]}, {60'd0, m_cnt[l]});
      end
      exp_rdy = !flush && (!m_valid[in_sel] || out_ready[in_sel]);
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      for (int l = 0; l < N; l++) begin
        if (m_valid[l] && sb[l].size() > 0) begin
          exp_word = sb[l][0];
          check("lane_data", {32'd0, out_data[l*W +: W]}, {32'd0, exp_word});
          if (out_ready[l]) begin
            void'(sb[l].pop_front());
            m_cnt[l] = m_cnt[l] + 1'b1;
            m_valid[l] = 1'b0;
          end
        end
      end
      if (flush) begin
        m_valid = '0;
        for (int l = 0; l < N; l++) sb[l].delete();
      end
      if (in_valid && exp_rdy) begin
        sb[in_sel].push_back(in_data);
        m_valid[in_sel] = 1'b1;
      end
    end
  end

  initial begin
    cyc();
    cyc();
    check("init_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;

    // Basic route to lane 2
    out_ready = 4'b1111;
    in_data = 32'hDEADBEEF; in_sel = 2'd2; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("route_valid", {60'd0, out_valid}, 64'h4);
    check("route_data", {32'd0, out_data[2*W +: W]}, 64'hDEADBEEF);
    cyc();
    check("route_drained", {60'd0, out_valid}, 64'h0);
    check("route_cnt2", {60'd0, out_cnt[2*CW +: CW]}, 64'd1);

    // Backpressure isolation: lane 1 stalled, lane 3 still accepts
    out_ready = 4'b0000;
    in_data = 32'h11111111; in_sel = 2'd1; in_valid = 1'b1;
    cyc();
    in_data = 32'h22222222;
    #1;
    check("bp_blocked", {63'd0, in_ready}, 64'd0);
    cyc();
    check("bp_hold1", {32'd0, out_data[1*W +: W]}, 64'h11111111);
    in_data = 32'h33333333; in_sel = 2'd3;
    #1;
    check("bp_other_lane", {63'd0, in_ready}, 64'd1);
    cyc();
    in_valid = 1'b0;
    check("bp_valid", {60'd0, out_valid}, 64'hA);
    check("bp_lane3", {32'd0, out_data[3*W +: W]}, 64'h33333333);
    check("bp_lane1", {32'd0, out_data[1*W +: W]}, 64'h11111111);
    out_ready = 4'b1111;
    cyc();
    cyc();

    // Full throughput on lane 0
    for (int i = 0; i < 8; i++) begin
      in_data = i; in_sel = 2'd0; in_valid = 1'b1;
      #1;
      check("tp_in_ready", {63'd0, in_ready}, 64'd1);
      cyc();
      check("tp_data", {32'd0, out_data[0 +: W]}, i);
      check("tp_valid", {63'd0, out_valid[0]}, 64'd1);
    end
    in_valid = 1'b0;
    cyc();
    check("tp_cnt0", {60'd0, out_cnt[0 +: CW]}, 64'd8);

    // Flush with lanes 0 and 3 full and stalled
    out_ready = 4'b0000;
    in_data = 32'hA0A0A0A0; in_sel = 2'd0; in_valid = 1'b1;
    cyc();
    in_data = 32'hA3A3A3A3; in_sel = 2'd3;
    cyc();
    check("fl_pre_valid", {60'd0, out_valid}, 64'h9);
    flush = 1'b1; in_data = 32'hFFFFFFFF; in_sel = 2'd2;
    #1;
    check("fl_in_ready", {63'd0, in_ready}, 64'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", {60'd0, out_valid}, 64'h0);
    check("fl_cnt", {48'd0, out_cnt}, 64'h1118);

    // Delivery in the flush cycle still counts
    in_data = 32'hB2B2B2B2; in_sel = 2'd2; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b1; out_ready = 4'b0100;
    cyc();
    flush = 1'b0; out_ready = 4'b0000;
    check("fl_dlv_cnt2", {60'd0, out_cnt[2*CW +: CW]}, 64'd2);
    check("fl_dlv_valid", {60'd0, out_valid}, 64'h0);

    // Asynchronous reset with lane 2 full
    in_data = 32'hC2C2C2C2; in_sel = 2'd2; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("rs_pre_valid", {60'd0, out_valid}, 64'h4);
    #2;
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0;
    #1;
    check("rs_valid", {60'd0, out_valid}, 64'h0);
    check("rs_cnt", {48'd0, out_cnt}, 64'h0);
    check("rs_in_ready", {63'd0, in_ready}, 64'd0);
    cyc();
    rst = 1'b0; in_valid = 1'b0;

    // Counter wrap on lane 1
    out_ready = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      in_data = 32'h100 + i; in_sel = 2'd1; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("wrap_cnt1", {60'd0, out_cnt[1*CW +: CW]}, 64'd1);
    check("wrap_others", {48'd0, out_cnt & 16'hFF0F}, 64'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
